game_sequencer: RTL and testbench

- Top-level game-flow controller for the paddle/brick game.
- Sequences the frame-tick-driven datapath blocks: paddle, ball, bricks, score counter and seven-segment score.
- Decides when the ball moves, when the paddle responds, when the ball re-centres, when score counts and clears, and tracks lives and remaining bricks.
- Sits between the debouncers and the VGA-side game objects; all decisions are taken at `clk` rate and gated by the per-frame tick.

---
 rtl/game_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller for the paddle/brick game: serve, play, loss and end states gated by frame_tick.
// Pause support is compiled in only when GAME_PAUSE_EN is defined.
module game_sequencer #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned BRICKS       = 32,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned LOST_FRAMES  = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       brick_hit,
    input  logic       ball_lost,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       paddle_en,
    output logic       ball_reset,
    output logic       score_clr,
    output logic       score_inc,
    output logic [2:0] lives,
    output logic [7:0] bricks_left,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        LOST  = 3'd4,
        OVER  = 3'd5,
        WIN   = 3'd6
    } state_t;

    state_t     state_q;
    logic [7:0] timer;
    logic [3:0] flags;
    logic       start_prev;
    logic       start_rise;
    logic       timer_done;
    logic       last_brick;

    assign start_rise = start_btn & ~start_prev;
    // A tick at timer 0 cannot happen normally; treat it as expiry so the FSM never stalls.
    assign timer_done = (timer <= 8'd1);
    assign last_brick = brick_hit && (bricks_left == 8'd1);

`ifdef GAME_PAUSE_EN
    logic pause_prev;
    logic pause_rise;

    assign pause_rise = pause_btn & ~pause_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_prev <= 1'b0;
        end else begin
            pause_prev <= pause_btn;
        end
    end
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    // Level outputs {ball_run, paddle_en, game_over, game_won} registered alongside each state change.
    function automatic logic [3:0] level_flags(input state_t s);
        case (s)
            SERVE:   level_flags = 4'b0100;
            PLAY:    level_flags = 4'b1100;
            OVER:    level_flags = 4'b0010;
            WIN:     level_flags = 4'b0001;
            default: level_flags = 4'b0000;
        endcase
    endfunction

    assign state = state_q;
    assign {ball_run, paddle_en, game_over, game_won} = flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flags       <= '0;
            lives       <= 3'(LIVES);
            bricks_left <= 8'(BRICKS);
            timer       <= '0;
            start_prev  <= 1'b0;
            ball_reset  <= 1'b0;
            score_clr   <= 1'b0;
            score_inc   <= 1'b0;
        end else begin
            start_prev <= start_btn;
            ball_reset <= 1'b0;
            score_clr  <= 1'b0;
            score_inc  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_q     <= SERVE;
                        flags       <= level_flags(SERVE);
                        score_clr   <= 1'b1;
                        ball_reset  <= 1'b1;
                        lives       <= 3'(LIVES);
                        bricks_left <= 8'(BRICKS);
                        timer       <= 8'(SERVE_FRAMES);
                    end
                end

                SERVE: begin
                    if (frame_tick) begin
                        timer <= timer_done ? '0 : timer - 8'd1;
                        if (timer_done) begin
                            state_q <= PLAY;
                            flags   <= level_flags(PLAY);
                        end
                    end
                end

                PLAY: begin
                    // The brick is always scored; a simultaneous loss only counts if the level is not cleared.
                    if (brick_hit) begin
                        score_inc <= 1'b1;
                        if (bricks_left != '0) begin
                            bricks_left <= bricks_left - 8'd1;
                        end
                    end
                    if (last_brick) begin
                        state_q <= WIN;
                        flags   <= level_flags(WIN);
                    end else if (ball_lost) begin
                        if (lives != '0) begin
                            lives <= lives - 3'd1;
                        end
                        timer   <= 8'(LOST_FRAMES);
                        state_q <= LOST;
                        flags   <= level_flags(LOST);
                    end
`ifdef GAME_PAUSE_EN
                    else if (pause_rise && !brick_hit) begin
                        state_q <= PAUSE;
                        flags   <= level_flags(PAUSE);
                    end
`endif
                end

`ifdef GAME_PAUSE_EN
                PAUSE: begin
                    if (pause_rise) begin
                        state_q <= PLAY;
                        flags   <= level_flags(PLAY);
                    end
                end
`endif

                LOST: begin
                    if (frame_tick) begin
                        timer <= timer_done ? '0 : timer - 8'd1;
                        if (timer_done) begin
                            if (lives == '0) begin
                                state_q <= OVER;
                                flags   <= level_flags(OVER);
                            end else begin
                                state_q    <= SERVE;
                                flags      <= level_flags(SERVE);
                                ball_reset <= 1'b1;
                                timer      <= 8'(SERVE_FRAMES);
                            end
                        end
                    end
                end

                OVER, WIN: begin
                    if (start_rise) begin
                        state_q <= IDLE;
                        flags   <= level_flags(IDLE);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    flags   <= level_flags(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed vector table, pause sequence and randomized
// stimulus against a behavioural game model. Honours GAME_PAUSE_EN when defined.
module tb_game_sequencer;

    localparam int L  = 2;
    localparam int B  = 3;
    localparam int SF = 2;
    localparam int LF = 3;
`ifdef GAME_PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, frame_tick, start_btn, pause_btn, brick_hit, ball_lost;
    logic [2:0] state;
    logic       ball_run, paddle_en, ball_reset, score_clr, score_inc;
    logic [2:0] lives;
    logic [7:0] bricks_left;
    logic       game_over, game_won;
    logic [20:0] obs;

    int total = 0;
    int bad   = 0;

    game_sequencer #(
        .LIVES(L),
        .BRICKS(B),
        .SERVE_FRAMES(SF),
        .LOST_FRAMES(LF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .brick_hit(brick_hit),
        .ball_lost(ball_lost),
        .state(state),
        .ball_run(ball_run),
        .paddle_en(paddle_en),
        .ball_reset(ball_reset),
        .score_clr(score_clr),
        .score_inc(score_inc),
        .lives(lives),
        .bricks_left(bricks_left),
        .game_over(game_over),
        .game_won(game_won)
    );

    always #5 clk = ~clk;

    assign obs = {state, lives, bricks_left, ball_run, paddle_en, ball_reset,
                  score_clr, score_inc, game_over, game_won};

    typedef struct {
        logic        rst, st, pa, ft, bh, bl;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input bit rst, st, pa, ft, bh, bl,
                               input int es, el, eb,
                               input bit run, pad, brst, clr, inc, ovr, won);
        vec_t r;
        r.rst = rst; r.st = st; r.pa = pa; r.ft = ft; r.bh = bh; r.bl = bl;
        r.exp = {3'(es), 3'(el), 8'(eb), run, pad, brst, clr, inc, ovr, won};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, st, pa, ft, bh, bl);
        reset = rst; start_btn = st; pause_btn = pa;
        frame_tick = ft; brick_hit = bh; ball_lost = bl;
        @(posedge clk);
        #1;
    endtask

    // Behavioural game model: named phases as small integers, counters as plain ints.
    int m_phase, m_lives, m_bricks, m_timer;
    bit m_sp, m_pp, m_clr, m_brst, m_inc;

    task automatic model_step(input bit rst, st, pa, ft, bh, bl);
        bit sr, pr, won;
        sr = st && !m_sp;
        pr = PE && pa && !m_pp;
        m_clr = 0; m_brst = 0; m_inc = 0;
        if (rst) begin
            m_phase = 0; m_lives = L; m_bricks = B; m_timer = 0; m_sp = 0; m_pp = 0;
            return;
        end
        m_sp = st;
        m_pp = pa;
        case (m_phase)
            0: if (sr) begin
                m_phase = 1; m_clr = 1; m_brst = 1;
                m_lives = L; m_bricks = B; m_timer = SF;
            end
            1: if (ft) begin
                m_timer = m_timer - 1;
                if (m_timer <= 0) m_phase = 2;
            end
            2: begin
                won = bh && (m_bricks == 1);
                if (bh) begin
                    m_inc = 1;
                    if (m_bricks > 0) m_bricks = m_bricks - 1;
                end
                if (won) m_phase = 6;
                else if (bl) begin
                    if (m_lives > 0) m_lives = m_lives - 1;
                    m_timer = LF;
                    m_phase = 4;
                end else if (!bh && pr) m_phase = 3;
            end
            3: if (pr) m_phase = 2;
            4: if (ft) begin
                m_timer = m_timer - 1;
                if (m_timer <= 0) begin
                    if (m_lives == 0) m_phase = 5;
                    else begin
                        m_phase = 1; m_brst = 1; m_timer = SF;
                    end
                end
            end
            default: if (sr) m_phase = 0;
        endcase
    endtask

    function automatic logic [20:0] model_obs();
        return {3'(m_phase), 3'(m_lives), 8'(m_bricks),
                m_phase == 2, (m_phase == 1) || (m_phase == 2),
                m_brst, m_clr, m_inc, m_phase == 5, m_phase == 6};
    endfunction

    initial begin
        bit st_lvl, pa_lvl, r_rst, r_ft, r_bh, r_bl;

        reset = 1; start_btn = 0; pause_btn = 0; frame_tick = 0; brick_hit = 0; ball_lost = 0;

        //            rst st pa ft bh bl  state lives bricks  run pad brst clr inc ovr won
        tbl.push_back(v(1, 0, 0, 0, 0, 0,  0, 2, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1, 2, 3,  0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1, 2, 3,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 2, 3,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  2, 2, 3,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  2, 2, 2,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  2, 2, 2,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  2, 2, 2,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  2, 2, 1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  2, 2, 1,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  6, 2, 0,  0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  6, 2, 0,  0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  6, 2, 0,  0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0, 2, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 2, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1, 2, 3,  0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 2, 3,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  2, 2, 3,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  2, 2, 2,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  2, 2, 1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 1,  6, 2, 0,  0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  6, 2, 0,  0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0, 2, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 2, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1, 2, 3,  0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 2, 3,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  2, 2, 3,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  4, 1, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  4, 1, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  4, 1, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 1, 3,  0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 1,  1, 1, 3,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  2, 1, 3,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  4, 0, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  4, 0, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  4, 0, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  5, 0, 3,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  5, 0, 3,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  0, 0, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,  1, 2, 3,  0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 2, 3,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  2, 2, 3,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  2, 2, 2,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0,  2, 2, 1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1,  4, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  4, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  4, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 1, 1,  0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  1, 1, 1,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0,  2, 1, 1,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 1, 1,  0, 2, 3,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 2, 3,  0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].pa, tbl[i].ft, tbl[i].bh, tbl[i].bl);
            check($sformatf("vec[%0d]", i), 32'(obs), 32'(tbl[i].exp));
        end

        // Pause sequence: the same stimulus is expected to pause only when the feature is built in.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 1, 0, 0);
        check("pause_pre_state", 32'(state), 32'd2);
        drive(0, 1, 1, 0, 0, 0);
        check("pause_enter_state", 32'(state), PE ? 32'd3 : 32'd2);
        check("pause_enter_run", 32'(ball_run), PE ? 32'd0 : 32'd1);
        drive(0, 1, 1, 0, 1, 0);
        check("pause_hit_bricks", 32'(bricks_left), PE ? 32'd3 : 32'd2);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 1, 1, 0, 0);
            check($sformatf("pause_tick[%0d]", k), 32'(state), PE ? 32'd3 : 32'd2);
        end
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        check("pause_resume_state", 32'(state), 32'd2);
        check("pause_resume_run", 32'(ball_run), 32'd1);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 0);
        check("pause_vs_hit_state", 32'(state), 32'd2);
        check("pause_vs_hit_bricks", 32'(bricks_left), PE ? 32'd2 : 32'd1);

        // Randomized play against the behavioural model.
        st_lvl = 0;
        pa_lvl = 0;
        model_step(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rand_reset", 32'(obs), 32'(model_obs()));
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) st_lvl = ~st_lvl;
            if ($urandom_range(0, 3) == 0) pa_lvl = ~pa_lvl;
            r_ft  = ($urandom_range(0, 3) == 0);
            r_bh  = ($urandom_range(0, 7) == 0);
            r_bl  = ($urandom_range(0, 11) == 0);
            r_rst = ($urandom_range(0, 299) == 0);
            model_step(r_rst, st_lvl, pa_lvl, r_ft, r_bh, r_bl);
            drive(r_rst, st_lvl, pa_lvl, r_ft, r_bh, r_bl);
            check($sformatf("rand[%0d]", n), 32'(obs), 32'(model_obs()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
